// File: rtl/rfphoenix_thread_ready_tracker_pkg.sv
// Shared thread-select types: thread count, thread id and per-thread issue state.
package rfPhoenixPkg;
  localparam int NTHREADS = 8;
  localparam int TIDW     = $clog2(NTHREADS);

  typedef logic [TIDW-1:0] Tid;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    SLEEP = 2'd3
  } ThreadState;
endpackage

// File: rtl/rfphoenix_thread_ready_slot.sv
// One thread's issue-eligibility FSM and in-flight counter.
// RFPHOENIX_RDY_TIMEOUT_EN adds a stuck-count watchdog that re-arms the thread.
module rfphoenix_thread_ready_slot
  import rfPhoenixPkg::*;
#(
  parameter int MAXINFLIGHT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sel,
  input  logic       ret,
  input  logic       miss,
  input  logic       mdone,
  input  logic       sleep,
  input  logic       wake,
  output logic       rdy,
  output logic [2:0] cnt,
  output logic       err,
  output logic       tmo
);
  localparam logic [2:0] MAXC = 3'(MAXINFLIGHT);

  ThreadState st, st_n;
  logic [2:0] cnt_n;
  logic       ok;
  logic       hit;

  assign ok  = (st == RUN) && (cnt < MAXC);
  assign rdy = ok;
  // A grant and a retire in the same cycle cancel out, so neither is judged on its own.
  assign err = (sel && !ret && !ok) || (ret && !sel && (cnt == 3'd0));

  always_comb begin
    st_n = st;
    if (!en) st_n = OFF;
    else begin
      case (st)
        OFF:     st_n = RUN;
        RUN:     if (miss) st_n = MISS; else if (sleep) st_n = SLEEP;
        MISS:    if (mdone) st_n = RUN;
        SLEEP:   if (wake) st_n = RUN;
        default: st_n = OFF;
      endcase
    end
  end

  always_comb begin
    cnt_n = cnt;
    if (sel && !ret && ok)                     cnt_n = cnt + 3'd1;
    else if (ret && !sel && (cnt != 3'd0))     cnt_n = cnt - 3'd1;
    if (!en)      cnt_n = 3'd0;
    else if (hit) cnt_n = 3'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= OFF;
      cnt <= 3'd0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

`ifdef RFPHOENIX_RDY_TIMEOUT_EN
  logic [9:0] tmr;
  logic       tmo_q;

  assign hit = &tmr;
  assign tmo = tmo_q;

  // Timer only runs while a nonzero count sits unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr   <= 10'd0;
      tmo_q <= 1'b0;
    end else begin
      tmr <= ((cnt_n != cnt) || (cnt == 3'd0)) ? 10'd0 : tmr + 10'd1;
      if (!en)      tmo_q <= 1'b0;
      else if (hit) tmo_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
  assign tmo = 1'b0;
`endif
endmodule

// File: rtl/rfphoenix_thread_ready_tracker.sv
// Thread request-vector producer for the round-robin selector; decodes event tids
// and instantiates one slot per thread. Optional timeouts: RFPHOENIX_RDY_TIMEOUT_EN.
module rfphoenix_thread_ready_tracker
  import rfPhoenixPkg::*;
#(
  parameter int NTHREADS    = rfPhoenixPkg::NTHREADS,
  parameter int MAXINFLIGHT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NTHREADS-1:0]   en_i,
  input  logic                  sel_v_i,
  input  Tid                    sel_tid_i,
  input  logic                  ret_v_i,
  input  Tid                    ret_tid_i,
  input  logic                  miss_v_i,
  input  Tid                    miss_tid_i,
  input  logic                  mdone_v_i,
  input  Tid                    mdone_tid_i,
  input  logic                  sleep_v_i,
  input  Tid                    sleep_tid_i,
  input  logic [NTHREADS-1:0]   wake_i,
  output logic [NTHREADS-1:0]   rdy_o,
  output logic [NTHREADS*3-1:0] inflight_o,
  output logic                  err_o,
  output logic [NTHREADS-1:0]   tmo_o
);
  logic [NTHREADS-1:0] sel_oh, ret_oh, miss_oh, mdone_oh, sleep_oh;
  logic [NTHREADS-1:0] rdy_q, err_v;
  logic                err_q;

  for (genvar t = 0; t < NTHREADS; t++) begin : g_slot
    assign sel_oh[t]   = sel_v_i   && (sel_tid_i   == Tid'(t));
    assign ret_oh[t]   = ret_v_i   && (ret_tid_i   == Tid'(t));
    assign miss_oh[t]  = miss_v_i  && (miss_tid_i  == Tid'(t));
    assign mdone_oh[t] = mdone_v_i && (mdone_tid_i == Tid'(t));
    assign sleep_oh[t] = sleep_v_i && (sleep_tid_i == Tid'(t));

    rfphoenix_thread_ready_slot #(.MAXINFLIGHT(MAXINFLIGHT)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .en    (en_i[t]),
      .sel   (sel_oh[t]),
      .ret   (ret_oh[t]),
      .miss  (miss_oh[t]),
      .mdone (mdone_oh[t]),
      .sleep (sleep_oh[t]),
      .wake  (wake_i[t]),
      .rdy   (rdy_q[t]),
      .cnt   (inflight_o[3*t +: 3]),
      .err   (err_v[t]),
      .tmo   (tmo_o[t])
    );
  end

  // Same-cycle mask keeps the selector from re-granting the thread it just picked.
  assign rdy_o = rdy_q & ~sel_oh;
  assign err_o = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        err_q <= 1'b0;
    else if (|err_v) err_q <= 1'b1;
  end
endmodule
